// File: rtl/epsp_tdm_scheduler.sv
// Time-multiplexes one external second-order IIR datapath across NCH spike channels,
// keeping per-channel filter history and publishing the per-channel filter outputs.
module epsp_tdm_scheduler #(
    parameter int unsigned NCH = 8,
    parameter int unsigned LAT = 0,
    parameter int unsigned CW  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                clr,
    input  logic [32*NCH-1:0]   x_in_flat,
    output logic [31:0]         dp_x1,
    output logic [31:0]         dp_x2,
    output logic [31:0]         dp_y1,
    output logic [31:0]         dp_y2,
    output logic                dp_valid,
    output logic [CW-1:0]       dp_ch,
    input  logic [31:0]         dp_y,
    output logic [32*NCH-1:0]   y_flat,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    localparam int unsigned DW = 32;
    localparam int unsigned LW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [LW-1:0]   wcnt_q, wcnt_d;
    logic            pend_clr_q, pend_clr_d;
    logic            overrun_q, overrun_d;
    logic            do_clr, do_snap, do_write;

    logic [DW-1:0]   snap_q [NCH];
    logic [DW-1:0]   hx1_q  [NCH];
    logic [DW-1:0]   hx2_q  [NCH];
    logic [DW-1:0]   hy1_q  [NCH];
    logic [DW-1:0]   hy2_q  [NCH];
    logic [DW-1:0]   yo_q   [NCH];

    logic [DW-1:0]   sel_x1, sel_x2, sel_y1, sel_y2;
    logic [DW-1:0]   dpx1_q, dpx2_q, dpy1_q, dpy2_q;
    logic            dpv_q;
    logic [CW-1:0]   dpch_q;
    logic            busy_q, done_q;

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            wcnt_q     <= '0;
            pend_clr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            wcnt_q     <= wcnt_d;
            pend_clr_q <= pend_clr_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and datapath control strobes
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        wcnt_d     = wcnt_q;
        pend_clr_d = pend_clr_q;
        overrun_d  = overrun_q;
        do_clr     = 1'b0;
        do_snap    = 1'b0;
        do_write   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    do_clr = 1'b1;
                end else if (tick) begin
                    do_snap = 1'b1;
                    ch_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = (LAT > 0) ? S_WAIT : S_WRITE;
            end
            S_WAIT: begin
                if (wcnt_q == LW'(LAT - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    wcnt_d = wcnt_q + LW'(1);
                end
            end
            S_WRITE: begin
                do_write = 1'b1;
                if (ch_q == CW'(NCH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                // A clear landing on the final cycle is folded into the deferred one
                do_clr     = pend_clr_q | clr;
                pend_clr_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && tick) begin
            overrun_d = 1'b1;
        end
        if ((state_q == S_ISSUE || state_q == S_WAIT || state_q == S_WRITE) && clr) begin
            pend_clr_d = 1'b1;
        end
    end

    // History of the channel about to be issued
    always_comb begin
        sel_x1 = '0;
        sel_x2 = '0;
        sel_y1 = '0;
        sel_y2 = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_d == CW'(k)) begin
                sel_x1 = hx1_q[k];
                sel_x2 = hx2_q[k];
                sel_y1 = hy1_q[k];
                sel_y2 = hy2_q[k];
            end
        end
    end

    // Registered datapath operands and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dpx1_q <= '0;
            dpx2_q <= '0;
            dpy1_q <= '0;
            dpy2_q <= '0;
            dpch_q <= '0;
            dpv_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dpv_q  <= (state_d == S_ISSUE);
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_DONE);
            if (state_d == S_ISSUE) begin
                dpch_q <= ch_d;
                dpx1_q <= sel_x1;
                dpx2_q <= sel_x2;
                dpy1_q <= sel_y1;
                dpy2_q <= sel_y2;
            end
        end
    end

    // Per-channel history, input snapshot and published outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                snap_q[k] <= '0;
                hx1_q[k]  <= '0;
                hx2_q[k]  <= '0;
                hy1_q[k]  <= '0;
                hy2_q[k]  <= '0;
                yo_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (do_clr) begin
                    hx1_q[k] <= '0;
                    hx2_q[k] <= '0;
                    hy1_q[k] <= '0;
                    hy2_q[k] <= '0;
                    yo_q[k]  <= '0;
                end else if (do_write && ch_q == CW'(k)) begin
                    // The frame's own input enters history only after its evaluation
                    hx2_q[k] <= hx1_q[k];
                    hx1_q[k] <= snap_q[k];
                    hy2_q[k] <= hy1_q[k];
                    hy1_q[k] <= dp_y;
                    yo_q[k]  <= dp_y;
                end
                if (do_snap) begin
                    snap_q[k] <= x_in_flat[DW*k +: DW];
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign y_flat[DW*g +: DW] = yo_q[g];
    end

    assign dp_x1      = dpx1_q;
    assign dp_x2      = dpx2_q;
    assign dp_y1      = dpy1_q;
    assign dp_y2      = dpy2_q;
    assign dp_valid   = dpv_q;
    assign dp_ch      = dpch_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_epsp_tdm_scheduler.sv
// Bench for epsp_tdm_scheduler: two instances (LAT=2 and LAT=0, NCH=4) share stimulus;
// each has its own datapath model y = 0.5*x1 + 0.5*y1 and results are checked against a frame-level model.
module tb_epsp_tdm_scheduler;

    localparam int unsigned NCH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          clr = 1'b0;
    logic [127:0]  x_in = '0;

    logic [31:0]   dx1 [2];
    logic [31:0]   dx2 [2];
    logic [31:0]   dy1 [2];
    logic [31:0]   dy2 [2];
    logic [31:0]   dy  [2];
    logic          dv  [2];
    logic [1:0]    dch [2];
    logic [127:0]  yf  [2];
    logic          bsy [2];
    logic          fd  [2];
    logic          ov  [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    epsp_tdm_scheduler #(.NCH(4), .LAT(2), .CW(2)) u_lat2 (
        .clk(clk), .reset(reset), .tick(tick), .clr(clr), .x_in_flat(x_in),
        .dp_x1(dx1[0]), .dp_x2(dx2[0]), .dp_y1(dy1[0]), .dp_y2(dy2[0]),
        .dp_valid(dv[0]), .dp_ch(dch[0]), .dp_y(dy[0]), .y_flat(yf[0]),
        .busy(bsy[0]), .frame_done(fd[0]), .overrun(ov[0])
    );

    epsp_tdm_scheduler #(.NCH(4), .LAT(0), .CW(2)) u_lat0 (
        .clk(clk), .reset(reset), .tick(tick), .clr(clr), .x_in_flat(x_in),
        .dp_x1(dx1[1]), .dp_x2(dx2[1]), .dp_y1(dy1[1]), .dp_y2(dy2[1]),
        .dp_valid(dv[1]), .dp_ch(dch[1]), .dp_y(dy[1]), .y_flat(yf[1]),
        .busy(bsy[1]), .frame_done(fd[1]), .overrun(ov[1])
    );

    // Non-negative single <-> double conversions (values used here are exact)
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        if (f[30:0] == 31'h0) return 0.0;
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] fmac(input logic [31:0] a, input logic [31:0] b);
        return r2f(0.5 * f2r(a) + 0.5 * f2r(b));
    endfunction

    function automatic logic [31:0] rnd_f();
        return r2f(real'($urandom_range(1, 1000)) / 8.0);
    endfunction

    function automatic logic [127:0] rnd_x();
        return {rnd_f(), rnd_f(), rnd_f(), rnd_f()};
    endfunction

    // External datapath: result is garbage until LAT cycles after issue
    for (genvar g = 0; g < 2; g++) begin : g_dp
        localparam int unsigned LATG = (g == 0) ? 2 : 0;
        logic [2:0] cnt = '0;
        always @(posedge clk or posedge reset) begin
            if (reset) cnt <= '0;
            else if (dv[g]) cnt <= 3'd1;
            else if (cnt != 3'd7) cnt <= cnt + 3'd1;
        end
        assign dy[g] = (!dv[g] && cnt >= 3'(LATG)) ? fmac(dx1[g], dy1[g]) : 32'hDEADBEEF;
    end

    // Frame-level reference model
    logic [31:0] mx1 [4];
    logic [31:0] mx2 [4];
    logic [31:0] my1 [4];
    logic [31:0] my2 [4];
    logic [31:0] ey  [4];

    task automatic model_clr();
        for (int k = 0; k < 4; k++) begin
            mx1[k] = '0; mx2[k] = '0; my1[k] = '0; my2[k] = '0; ey[k] = '0;
        end
    endtask

    task automatic model_frame(input logic [127:0] x);
        logic [31:0] yn;
        for (int k = 0; k < 4; k++) begin
            yn = fmac(mx1[k], my1[k]);
            ey[k] = yn;
            mx2[k] = mx1[k];
            mx1[k] = x[32*k +: 32];
            my2[k] = my1[k];
            my1[k] = yn;
        end
    endtask

    function automatic logic [127:0] pack_ey();
        return {ey[3], ey[2], ey[1], ey[0]};
    endfunction

    // Per-frame observations
    int           dcyc [2];
    int           nv   [2];
    int           vcyc [2][4];
    logic [1:0]   vch  [2][4];
    logic [127:0] vop  [2][4];
    logic [127:0] ydone  [2];
    logic [127:0] yafter [2];

    task automatic run_frame(input logic [127:0] xin, input int tick2_at, input int clr_at);
        int cyc;
        x_in = xin;
        for (int i = 0; i < 2; i++) begin
            dcyc[i] = -1; nv[i] = 0; ydone[i] = '0; yafter[i] = '1;
            for (int k = 0; k < 4; k++) begin
                vcyc[i][k] = -1; vch[i][k] = '0; vop[i][k] = '1;
            end
        end
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        cyc = 1;
        while (cyc < 80) begin
            tick = (cyc == tick2_at);
            clr  = (cyc == clr_at);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (dv[i]) begin
                    if (nv[i] < 4) begin
                        vcyc[i][nv[i]] = cyc;
                        vch[i][nv[i]]  = dch[i];
                        vop[i][nv[i]]  = {dx1[i], dx2[i], dy1[i], dy2[i]};
                    end
                    nv[i]++;
                end
                if (fd[i] && dcyc[i] < 0) begin
                    dcyc[i]  = cyc;
                    ydone[i] = yf[i];
                end
                if (dcyc[i] >= 0 && cyc == dcyc[i] + 1) yafter[i] = yf[i];
            end
            @(posedge clk); #1;
            cyc++;
            if (dcyc[0] >= 0 && dcyc[1] >= 0 && cyc > dcyc[0] + 1 && cyc > dcyc[1] + 1) break;
        end
        tick = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic test_reset();
        bit seen_v, seen_b;
        seen_v = 0; seen_b = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (dv[i]) seen_v = 1;
                if (bsy[i]) seen_b = 1;
            end
        end
        total++; if (seen_v !== 1'b0) begin bad++; $display("FAIL reset_dp_valid: got %b want 0", seen_v); end
        total++; if (seen_b !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", seen_b); end
        for (int i = 0; i < 2; i++) begin
            total++; if (yf[i] !== '0) begin bad++; $display("FAIL reset_yflat dut%0d: got %h want 0", i, yf[i]); end
            total++; if (ov[i] !== 1'b0) begin bad++; $display("FAIL reset_overrun dut%0d: got %b want 0", i, ov[i]); end
            total++; if (fd[i] !== 1'b0) begin bad++; $display("FAIL reset_frame_done dut%0d: got %b want 0", i, fd[i]); end
            total++; if ({dx1[i], dx2[i], dy1[i], dy2[i]} !== '0) begin
                bad++; $display("FAIL reset_operands dut%0d: got %h want 0", i, {dx1[i], dx2[i], dy1[i], dy2[i]});
            end
        end
        model_clr();
    endtask

    task automatic test_impulse();
        logic [127:0] xin;
        logic [31:0]  want;
        for (int f = 0; f < 3; f++) begin
            xin  = (f == 0) ? 128'h3F800000 : 128'h0;
            want = (f == 0) ? 32'h0 : (f == 1) ? 32'h3F000000 : 32'h3E800000;
            run_frame(xin, -1, -1);
            model_frame(xin);
            for (int i = 0; i < 2; i++) begin
                total++; if (yf[i][31:0] !== want) begin
                    bad++; $display("FAIL impulse_ch0 dut%0d frame%0d: got %h want %h", i, f, yf[i][31:0], want);
                end
                total++; if (yf[i][127:32] !== 96'h0) begin
                    bad++; $display("FAIL impulse_others dut%0d frame%0d: got %h want 0", i, f, yf[i][127:32]);
                end
            end
        end
    endtask

    task automatic test_timing_data();
        logic [127:0] xin;
        int slot;
        for (int f = 0; f < 4; f++) begin
            xin = rnd_x();
            run_frame(xin, -1, -1);
            for (int i = 0; i < 2; i++) begin
                slot = (i == 0) ? 4 : 2;
                total++; if (dcyc[i] !== 1 + 4 * slot) begin
                    bad++; $display("FAIL frame_len dut%0d frame%0d: got %0d want %0d", i, f, dcyc[i], 1 + 4 * slot);
                end
                total++; if (nv[i] !== 4) begin
                    bad++; $display("FAIL valid_count dut%0d frame%0d: got %0d want 4", i, f, nv[i]);
                end
                for (int k = 0; k < 4; k++) begin
                    total++; if (vcyc[i][k] !== 1 + k * slot) begin
                        bad++; $display("FAIL valid_cycle dut%0d ch%0d: got %0d want %0d", i, k, vcyc[i][k], 1 + k * slot);
                    end
                    total++; if (vch[i][k] !== 2'(k)) begin
                        bad++; $display("FAIL valid_ch dut%0d slot%0d: got %0d want %0d", i, k, vch[i][k], k);
                    end
                    total++; if (vop[i][k] !== {mx1[k], mx2[k], my1[k], my2[k]}) begin
                        bad++; $display("FAIL operands dut%0d ch%0d: got %h want %h", i, k, vop[i][k],
                                        {mx1[k], mx2[k], my1[k], my2[k]});
                    end
                end
            end
            model_frame(xin);
            for (int i = 0; i < 2; i++) begin
                total++; if (yf[i] !== pack_ey()) begin
                    bad++; $display("FAIL frame_yflat dut%0d frame%0d: got %h want %h", i, f, yf[i], pack_ey());
                end
            end
        end
    endtask

    task automatic test_clr();
        logic [127:0] xin;
        bit seen_b;
        xin = rnd_x();
        run_frame(xin, -1, 3);
        model_frame(xin);
        for (int i = 0; i < 2; i++) begin
            total++; if (dcyc[i] !== ((i == 0) ? 17 : 9)) begin
                bad++; $display("FAIL clr_frame_len dut%0d: got %0d want %0d", i, dcyc[i], (i == 0) ? 17 : 9);
            end
            total++; if (ydone[i] !== pack_ey() || ydone[i] == '0) begin
                bad++; $display("FAIL clr_published dut%0d: got %h want %h (nonzero)", i, ydone[i], pack_ey());
            end
            total++; if (yafter[i] !== '0) begin
                bad++; $display("FAIL clr_zeroed dut%0d: got %h want 0", i, yafter[i]);
            end
        end
        model_clr();
        for (int f = 0; f < 2; f++) begin
            xin = rnd_x();
            run_frame(xin, -1, -1);
            model_frame(xin);
            for (int i = 0; i < 2; i++) begin
                total++; if (yf[i] !== pack_ey()) begin
                    bad++; $display("FAIL clr_history dut%0d frame%0d: got %h want %h", i, f, yf[i], pack_ey());
                end
            end
        end
        @(posedge clk); #1 begin tick = 1'b1; clr = 1'b1; end
        @(posedge clk); #1 begin tick = 1'b0; clr = 1'b0; end
        seen_b = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (bsy[i] || dv[i]) seen_b = 1;
        end
        model_clr();
        total++; if (seen_b !== 1'b0) begin bad++; $display("FAIL clr_tick_idle_busy: got %b want 0", seen_b); end
        for (int i = 0; i < 2; i++) begin
            total++; if (yf[i] !== '0) begin bad++; $display("FAIL clr_idle_yflat dut%0d: got %h want 0", i, yf[i]); end
            total++; if (ov[i] !== 1'b0) begin bad++; $display("FAIL clr_idle_overrun dut%0d: got %b want 0", i, ov[i]); end
        end
    endtask

    task automatic test_overrun();
        logic [127:0] xin;
        for (int f = 0; f < 2; f++) begin
            xin = rnd_x();
            run_frame(xin, (f == 0) ? 5 : -1, -1);
            model_frame(xin);
            for (int i = 0; i < 2; i++) begin
                total++; if (dcyc[i] !== ((i == 0) ? 17 : 9)) begin
                    bad++; $display("FAIL overrun_frame_len dut%0d frame%0d: got %0d want %0d", i, f, dcyc[i], (i == 0) ? 17 : 9);
                end
                total++; if (nv[i] !== 4) begin
                    bad++; $display("FAIL overrun_valid_count dut%0d frame%0d: got %0d want 4", i, f, nv[i]);
                end
                total++; if (ov[i] !== 1'b1) begin
                    bad++; $display("FAIL overrun_flag dut%0d frame%0d: got %b want 1", i, f, ov[i]);
                end
                total++; if (yf[i] !== pack_ey()) begin
                    bad++; $display("FAIL overrun_yflat dut%0d frame%0d: got %h want %h", i, f, yf[i], pack_ey());
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [127:0] xin;
        x_in = rnd_x();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        total++; if (dch[0] !== 2'd2 || bsy[0] !== 1'b1 || dv[0] !== 1'b0) begin
            bad++; $display("FAIL midframe_position: got ch=%0d busy=%b valid=%b want ch=2 busy=1 valid=0", dch[0], bsy[0], dv[0]);
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (yf[i] !== '0) begin bad++; $display("FAIL async_reset_yflat dut%0d: got %h want 0", i, yf[i]); end
            total++; if ({bsy[i], ov[i], dv[i], fd[i]} !== 4'b0) begin
                bad++; $display("FAIL async_reset_flags dut%0d: got %b want 0000", i, {bsy[i], ov[i], dv[i], fd[i]});
            end
            total++; if ({dx1[i], dx2[i], dy1[i], dy2[i], dch[i]} !== '0) begin
                bad++; $display("FAIL async_reset_operands dut%0d: got %h want 0", i, {dx1[i], dx2[i], dy1[i], dy2[i], dch[i]});
            end
        end
        @(negedge clk) reset = 1'b0;
        model_clr();
        for (int f = 0; f < 2; f++) begin
            xin = rnd_x();
            run_frame(xin, -1, -1);
            for (int i = 0; i < 2; i++) begin
                total++; if (dcyc[i] !== ((i == 0) ? 17 : 9)) begin
                    bad++; $display("FAIL post_reset_len dut%0d frame%0d: got %0d want %0d", i, f, dcyc[i], (i == 0) ? 17 : 9);
                end
                for (int k = 0; k < 4; k++) begin
                    total++; if (vch[i][k] !== 2'(k) || vop[i][k] !== {mx1[k], mx2[k], my1[k], my2[k]}) begin
                        bad++; $display("FAIL post_reset_issue dut%0d slot%0d: got ch=%0d ops=%h want ch=%0d ops=%h",
                                        i, k, vch[i][k], vop[i][k], k, {mx1[k], mx2[k], my1[k], my2[k]});
                    end
                end
            end
            model_frame(xin);
            for (int i = 0; i < 2; i++) begin
                total++; if (yf[i] !== pack_ey()) begin
                    bad++; $display("FAIL post_reset_yflat dut%0d frame%0d: got %h want %h", i, f, yf[i], pack_ey());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_timing_data();
        test_clr();
        test_overrun();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
